// File: rtl/main_memory_responder_pkg.sv
// Shared definitions for the main-memory responder: bus address width, latency limits,
// counter width and the responder FSM state encoding.
package main_memory_responder_pkg;

  localparam int ADDRESSSIZE     = 32;
  localparam int MEM_LATENCY_MIN = 1;
  localparam int MEM_LATENCY_MAX = 15;

  // Wide enough to hold MEM_LATENCY_MAX-1, the largest value ever loaded.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/main_memory_responder_if.sv
// Snooping-bus control signals seen by the memory responder; the tri-stated data lines
// stay plain inout ports on the responder.
interface main_memory_responder_if;
  import main_memory_responder_pkg::*;

  logic                   Bus_Active;
  logic                   Mem_wr;
  logic                   Shared_hit;
  logic [ADDRESSSIZE-1:0] Address_Com;
  logic                   Mem_busy;

  modport slave (
    input  Bus_Active,
    input  Mem_wr,
    input  Shared_hit,
    input  Address_Com,
    output Mem_busy
  );

  modport master (
    output Bus_Active,
    output Mem_wr,
    output Shared_hit,
    output Address_Com,
    input  Mem_busy
  );

endinterface

// File: rtl/main_memory_responder_mem_array.sv
// Backing store: synchronous write port, combinational read port, both addressed by the
// transaction index captured by the responder. Contents are deliberately not reset.
module main_memory_responder_mem_array #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/main_memory_responder.sv
// Memory-side responder on the shared snooping bus: answers granted read fills after
// MEM_LATENCY cycles and commits write-backs. Define MEM_STATS_EN to add Rd_count/Wr_count.
module main_memory_responder
  import main_memory_responder_pkg::*;
#(
  parameter int MEM_DEPTH   = 1024,
  parameter int MEM_LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  main_memory_responder_if.slave bus,
  inout  wire  [ADDRESSSIZE-1:0] Data_Bus_Com,
  inout  wire                    Data_in_Bus
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]            Rd_count,
  output logic [15:0]            Wr_count
`endif
);

  localparam int              IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);

  mem_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   wr_q, wr_d;
  logic [IDX_W-1:0]       addr_q, addr_d;
  logic [ADDRESSSIZE-1:0] wdata_q, wdata_d;

  logic                   resp;
  logic                   drv_data;
  logic                   mem_we;
  logic [ADDRESSSIZE-1:0] rd_data;

  // Bits above the index alias onto the same word and are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.Address_Com[ADDRESSSIZE-1:IDX_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.Bus_Active) begin
          addr_d = bus.Address_Com[IDX_W-1:0];
          wr_d   = bus.Mem_wr;
          if (bus.Mem_wr) begin
            wdata_d = Data_Bus_Com;
          end
          cnt_d   = LAT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A lost grant wins over a peer hit; writes never yield to a peer.
        if (!bus.Bus_Active) begin
          state_d = ST_IDLE;
        end else if (!wr_q && bus.Shared_hit) begin
          state_d = ST_DONE;
        end else if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // Parking here until the grant drops keeps a held grant from re-triggering.
        if (!bus.Bus_Active) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign resp     = (state_q == ST_RESP);
  assign drv_data = resp && !wr_q;
  assign mem_we   = resp && wr_q;

  main_memory_responder_mem_array #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (ADDRESSSIZE),
    .IDX_W (IDX_W)
  ) mem_array_I (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (rd_data)
  );

  assign Data_Bus_Com = drv_data ? rd_data : {ADDRESSSIZE{1'bz}};
  assign Data_in_Bus  = resp ? 1'b1 : 1'bz;
  assign bus.Mem_busy = (state_q != ST_IDLE);

`ifdef MEM_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (drv_data) begin
      rd_count_d = sat_inc16(rd_count_q);
    end
    if (mem_we) begin
      wr_count_d = sat_inc16(wr_count_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign Rd_count = rd_count_q;
  assign Wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: directed scenarios plus randomized
// transactions checked cycle by cycle against a transaction-level memory model.
module tb_main_memory_responder;
  import main_memory_responder_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT   = 4;
  localparam int NPOOL = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  main_memory_responder_if bus_if ();

  wire [ADDRESSSIZE-1:0] Data_Bus_Com;
  wire                   Data_in_Bus;
  logic                  tb_drv_en;
  logic [31:0]           tb_drv_data;

  // Released bus lines float to known values so "not driven" is observable.
  assign Data_Bus_Com = tb_drv_en ? tb_drv_data : {ADDRESSSIZE{1'bz}};
  pullup   (Data_Bus_Com);
  pulldown (Data_in_Bus);

`ifdef MEM_STATS_EN
  logic [15:0] Rd_count, Wr_count;
`endif

  main_memory_responder #(
    .MEM_DEPTH   (DEPTH),
    .MEM_LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .Data_Bus_Com (Data_Bus_Com),
    .Data_in_Bus  (Data_in_Bus)
`ifdef MEM_STATS_EN
    ,
    .Rd_count     (Rd_count),
    .Wr_count     (Wr_count)
`endif
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] ref_mem [DEPTH];
  int          rd_exp = 0;
  int          wr_exp = 0;
  logic [31:0] pool [NPOOL];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_released(input string tag);
    chk({tag, " busy"}, 32'(bus_if.Mem_busy), 32'd0);
    chk({tag, " din"},  32'(Data_in_Bus),     32'd0);
    chk({tag, " data"}, Data_Bus_Com,         32'hFFFF_FFFF);
  endtask

  // One granted transaction. abort_at/drop_at (1..LAT, 0 = none) name the WAIT cycle in
  // which Shared_hit rises or the grant drops; hold extends the grant past the response.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int abort_at, input int drop_at, input int hold);
    int          idx;
    bit          gone, aborted;
    logic        exp_busy, exp_din;
    logic [31:0] exp_data;
    idx = int'(addr % 32'(DEPTH));
    @(negedge clk);
    bus_if.Bus_Active  = 1'b1;
    bus_if.Mem_wr      = wr;
    bus_if.Address_Com = addr;
    bus_if.Shared_hit  = 1'b0;
    tb_drv_en          = wr;
    tb_drv_data        = wdata;
    @(posedge clk);
    #1;
    tb_drv_en          = 1'b0;
    bus_if.Address_Com = $urandom;
    bus_if.Mem_wr      = 1'($urandom);
    gone    = 1'b0;
    aborted = 1'b0;
    for (int k = 1; k <= LAT + 2 + hold; k++) begin
      @(negedge clk);
      gone     = (drop_at != 0) && (drop_at < k);
      aborted  = !wr && (abort_at != 0) && (abort_at < k);
      exp_busy = !gone;
      exp_din  = 1'b0;
      exp_data = 32'hFFFF_FFFF;
      if (!gone && !aborted && k == LAT + 1) begin
        exp_din = 1'b1;
        if (!wr) exp_data = ref_mem[idx];
      end
      chk($sformatf("busy %s a%0h c%0d", wr ? "wr" : "rd", addr, k), 32'(bus_if.Mem_busy), 32'(exp_busy));
      chk($sformatf("din %s a%0h c%0d", wr ? "wr" : "rd", addr, k), 32'(Data_in_Bus), 32'(exp_din));
      chk($sformatf("data %s a%0h c%0d", wr ? "wr" : "rd", addr, k), Data_Bus_Com, exp_data);
      if (k == drop_at)  bus_if.Bus_Active = 1'b0;
      if (k == abort_at) bus_if.Shared_hit = 1'b1;
    end
    if (drop_at == 0) begin
      if (wr) begin
        ref_mem[idx] = wdata;
        wr_exp++;
      end else if (!aborted) begin
        rd_exp++;
      end
    end
    bus_if.Bus_Active = 1'b0;
    bus_if.Shared_hit = 1'b0;
    @(negedge clk);
    chk_released($sformatf("idle after a%0h", addr));
  endtask

  initial begin
    int          wr_sel, ab, dr, p;
    logic [31:0] a;
    rst_n              = 1'b0;
    tb_drv_en          = 1'b0;
    tb_drv_data        = '0;
    bus_if.Bus_Active  = 1'b0;
    bus_if.Mem_wr      = 1'b0;
    bus_if.Shared_hit  = 1'b0;
    bus_if.Address_Com = '0;
    repeat (3) @(negedge clk);
    chk_released("reset");
`ifdef MEM_STATS_EN
    chk("rd_count reset", 32'(Rd_count), 32'd0);
    chk("wr_count reset", 32'(Wr_count), 32'd0);
`endif
    rst_n = 1'b1;

    // Read fill with the default latency.
    run_txn(1'b1, 32'h10, 32'hCAFE_0010, 0, 0, 0);
    run_txn(1'b0, 32'h10, 32'h0, 0, 0, 0);
    // Write-back then read-back.
    run_txn(1'b1, 32'h20, 32'h1234_5678, 0, 0, 1);
    run_txn(1'b0, 32'h20, 32'h0, 0, 0, 0);
    // Peer hit aborts a read; the grant is held in DONE.
    run_txn(1'b1, 32'h30, 32'hA5A5_3030, 0, 0, 0);
    run_txn(1'b0, 32'h30, 32'h0, 2, 0, 3);
    // Peer hit on a write is ignored.
    run_txn(1'b1, 32'h30, 32'h0BAD_F00D, 2, 0, 0);
    run_txn(1'b0, 32'h30, 32'h0, 0, 0, 0);
    // Grant lost mid-WAIT: no response, no write; then an aliased read.
    run_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 2, 0);
    run_txn(1'b0, 32'h10 + 32'(DEPTH), 32'h0, 0, 0, 0);
    chk("alias model", ref_mem[16], 32'hCAFE_0010);

    // Reset in the middle of WAIT of a write discards it and releases the bus at once.
    @(negedge clk);
    bus_if.Bus_Active  = 1'b1;
    bus_if.Mem_wr      = 1'b1;
    bus_if.Address_Com = 32'h20;
    tb_drv_en          = 1'b1;
    tb_drv_data        = 32'h7777_7777;
    @(posedge clk);
    #1 tb_drv_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_released("async reset");
    bus_if.Bus_Active = 1'b0;
    rd_exp = 0;
    wr_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 32'h20, 32'h0, 0, 0, 0);

    // Randomized traffic over a small address pool, with aliases on the upper bits.
    for (int i = 0; i < NPOOL; i++) begin
      pool[i] = 32'($urandom_range(0, DEPTH - 1));
      run_txn(1'b1, pool[i], $urandom, 0, 0, 0);
    end
    for (int n = 0; n < 40; n++) begin
      p      = int'($urandom_range(0, NPOOL - 1));
      a      = pool[p] + 32'(DEPTH) * 32'($urandom_range(0, 7));
      wr_sel = int'($urandom_range(0, 2));
      ab     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAT)) : 0;
      dr     = (ab == 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, LAT)) : 0;
      run_txn(wr_sel == 0, a, $urandom, ab, dr, int'($urandom_range(0, 3)));
    end

`ifdef MEM_STATS_EN
    chk("rd_count", 32'(Rd_count), 32'(rd_exp));
    chk("wr_count", 32'(Wr_count), 32'(wr_exp));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
